div_iter: RTL and testbench

//  Multi-cycle signed integer divider; inverse of the multiply path.
//  - Computes quotient = A / B, one quotient bit per clock (restoring, magnitude form).
//  - Sits beside the combinational ALU in execute; pipeline stalls on busy until data_resultRDY.
//  - Quotient truncates toward zero; remainder takes the dividend's sign.

---
 rtl/div_iter.sv | 198 +++++++++++++++++++
 tb/tb_div_iter.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/div_iter.sv
// div_iter: multi-cycle signed integer divider, one quotient bit per clock.
// Restoring division on operand magnitudes, then a sign-fix step. The
// quotient truncates toward zero and the remainder takes the dividend's sign.
//
// Optional feature macro: DIV_REMAINDER_EN adds the data_remainder output.
//
// Ports:
//   clock          rising-edge clock
//   reset          async active-low reset; forces idle and clears all outputs
//   ctrl_DIV       start pulse, sampled only while idle
//   data_operandA  dividend (two's complement), captured on accepted start
//   data_operandB  divisor (two's complement), captured on accepted start
//   data_result    signed quotient, held until the next result is produced
//   data_remainder signed remainder (DIV_REMAINDER_EN only)
//   data_exception divide-by-zero or MIN/-1 overflow, valid with data_resultRDY
//   data_resultRDY one-cycle done pulse
//   busy           high from accepted start until data_resultRDY rises
module div_iter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
`ifdef DIV_REMAINDER_EN
  output logic [WIDTH-1:0] data_remainder,
`endif
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] quo, quo_n;
  logic [WIDTH-1:0] rem, rem_n;
  logic [WIDTH-1:0] abs_b, abs_b_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             sign_q, sign_q_n;
  logic             exc_pend, exc_pend_n;
  logic [WIDTH-1:0] result_n;
  logic             exception_n;
  logic             rdy_n;
  logic             busy_n;
`ifdef DIV_REMAINDER_EN
  logic             sign_r, sign_r_n;
  logic [WIDTH-1:0] remainder_n;
`endif

  // Operand magnitudes; |MIN| comes out as the unsigned value 2^(WIDTH-1).
  logic [WIDTH-1:0] abs_a_in, abs_b_in;
  logic             a_is_min, b_is_zero, b_is_neg1;

  assign abs_a_in  = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
  assign abs_b_in  = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;
  assign a_is_min  = (data_operandA == {1'b1, {(WIDTH-1){1'b0}}});
  assign b_is_zero = (data_operandB == '0);
  assign b_is_neg1 = &data_operandB;

  // Trial subtract, WIDTH+1 bits wide. rem always stays below |B| <= 2^(WIDTH-1),
  // so {rem, next dividend bit} fits and trial[WIDTH] is a true borrow.
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] rem_sh;

  assign rem_sh = {rem[WIDTH-2:0], quo[WIDTH-1]};
  assign trial  = {rem, quo[WIDTH-1]} - {1'b0, abs_b};

  // Next-state and datapath/output next values.
  always_comb begin
    state_n     = state;
    quo_n       = quo;
    rem_n       = rem;
    abs_b_n     = abs_b;
    cnt_n       = cnt;
    sign_q_n    = sign_q;
    exc_pend_n  = exc_pend;
    result_n    = data_result;
    exception_n = data_exception;
    rdy_n       = 1'b0;
    busy_n      = 1'b0;
`ifdef DIV_REMAINDER_EN
    sign_r_n    = sign_r;
    remainder_n = data_remainder;
`endif

    unique case (state)
      IDLE: begin
        if (ctrl_DIV) begin
          sign_q_n    = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
`ifdef DIV_REMAINDER_EN
          sign_r_n    = data_operandA[WIDTH-1];
`endif
          abs_b_n     = abs_b_in;
          rem_n       = '0;
          cnt_n       = CNT_W'(WIDTH);
          exception_n = 1'b0;
          busy_n      = 1'b1;
          // Exceptions skip the iterations but still pass through FIX, which
          // produces result 0 (B==0) or MIN (MIN/-1 has sign_q=0, q=|MIN|).
          if (b_is_zero) begin
            quo_n      = '0;
            exc_pend_n = 1'b1;
            state_n    = FIX;
          end else if (a_is_min && b_is_neg1) begin
            quo_n      = abs_a_in;
            exc_pend_n = 1'b1;
            state_n    = FIX;
          end else begin
            quo_n      = abs_a_in;
            exc_pend_n = 1'b0;
            state_n    = ITER;
          end
        end
      end

      ITER: begin
        busy_n = 1'b1;
        if (!trial[WIDTH]) begin
          rem_n = trial[WIDTH-1:0];
          quo_n = {quo[WIDTH-2:0], 1'b1};
        end else begin
          rem_n = rem_sh;
          quo_n = {quo[WIDTH-2:0], 1'b0};
        end
        cnt_n = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          state_n = FIX;
        end
      end

      FIX: begin
        result_n    = sign_q ? -quo : quo;
`ifdef DIV_REMAINDER_EN
        remainder_n = sign_r ? -rem : rem;
`endif
        exception_n = exc_pend;
        rdy_n       = 1'b1;
        state_n     = DONE;
      end

      DONE: begin
        state_n = IDLE;
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      quo            <= '0;
      rem            <= '0;
      abs_b          <= '0;
      cnt            <= '0;
      sign_q         <= 1'b0;
      exc_pend       <= 1'b0;
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
      busy           <= 1'b0;
`ifdef DIV_REMAINDER_EN
      sign_r         <= 1'b0;
      data_remainder <= '0;
`endif
    end else begin
      state          <= state_n;
      quo            <= quo_n;
      rem            <= rem_n;
      abs_b          <= abs_b_n;
      cnt            <= cnt_n;
      sign_q         <= sign_q_n;
      exc_pend       <= exc_pend_n;
      data_result    <= result_n;
      data_exception <= exception_n;
      data_resultRDY <= rdy_n;
      busy           <= busy_n;
`ifdef DIV_REMAINDER_EN
      sign_r         <= sign_r_n;
      data_remainder <= remainder_n;
`endif
    end
  end

endmodule

// File: tb/tb_div_iter.sv
// tb_div_iter: scoreboard bench for div_iter (WIDTH=32). Expected quotient,
// remainder, exception flag and RDY edge are pushed when a start is driven and
// compared when data_resultRDY is seen. Build with DIV_REMAINDER_EN to also
// compare the remainder output.
module tb_div_iter;

  localparam int unsigned W = 32;
  localparam logic [W-1:0] MIN_V = {1'b1, {(W-1){1'b0}}};

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         ctrl_DIV = 1'b0;
  logic [W-1:0] data_operandA = '0;
  logic [W-1:0] data_operandB = '0;
  logic [W-1:0] data_result;
`ifdef DIV_REMAINDER_EN
  logic [W-1:0] data_remainder;
`endif
  logic         data_exception;
  logic         data_resultRDY;
  logic         busy;

  div_iter #(.WIDTH(W)) dut (
    .clock          (clock),
    .reset          (reset),
    .ctrl_DIV       (ctrl_DIV),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .data_result    (data_result),
`ifdef DIV_REMAINDER_EN
    .data_remainder (data_remainder),
`endif
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  always #5 clock = ~clock;

  int unsigned cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         exc;
    int unsigned  edge_rdy;
  } exp_t;

  exp_t         sb[$];
  int unsigned  n_checks = 0;
  int unsigned  n_fail = 0;
  logic [W-1:0] last_q = '0;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: native signed division, exceptions handled explicitly.
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    logic signed [W-1:0] sx, sy;
    sx = x;
    sy = y;
    e.edge_rdy = 0;
    if (y == '0) begin
      e.q = '0; e.r = '0; e.exc = 1'b1;
    end else if (x == MIN_V && y == '1) begin
      e.q = MIN_V; e.r = '0; e.exc = 1'b1;
    end else begin
      e.q = W'(sx / sy); e.r = W'(sx % sy); e.exc = 1'b0;
    end
    return e;
  endfunction

  // Drive one start pulse; optionally record the expected outcome.
  task automatic start_op(input logic [W-1:0] x, input logic [W-1:0] y, input bit push);
    exp_t e;
    @(negedge clock);
    data_operandA = x;
    data_operandB = y;
    ctrl_DIV = 1'b1;
    if (push) begin
      e = model(x, y);
      e.edge_rdy = cyc + 1 + (e.exc ? 1 : W + 1);
      sb.push_back(e);
    end
    @(negedge clock);
    ctrl_DIV = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clock);
    check("drain", W'(sb.size()), W'(0));
  endtask

  // Result monitor: every RDY pulse must match the oldest expectation.
  always @(negedge clock) begin
    exp_t e;
    if (reset && data_resultRDY) begin
      if (sb.size() == 0) begin
        check("stray_rdy", W'(data_resultRDY), W'(0));
      end else begin
        e = sb.pop_front();
        last_q = e.q;
        check("quotient", data_result, e.q);
        check("exception", W'(data_exception), W'(e.exc));
        check("rdy_cycle", W'(cyc), W'(e.edge_rdy));
        check("busy_at_rdy", W'(busy), W'(0));
`ifdef DIV_REMAINDER_EN
        check("remainder", data_remainder, e.r);
`endif
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  int da[12] = '{100, -100, 100, -100, 5, 32'h80000000, 32'h80000000, 32'h80000000,
                 7, -1, 0, 32'h7fffffff};
  int db[12] = '{7, 7, -7, -7, 0, -1, 1, 7, 32'h80000000, 1, 5, -1};

  initial begin
    logic [W-1:0] x, y;

    repeat (3) @(negedge clock);
    check("rst_result", data_result, W'(0));
    check("rst_exception", W'(data_exception), W'(0));
    check("rst_rdy", W'(data_resultRDY), W'(0));
    check("rst_busy", W'(busy), W'(0));
    reset = 1'b1;

    // Directed sign and boundary cases.
    for (int i = 0; i < 12; i++) begin
      start_op(W'(da[i]), W'(db[i]), 1'b1);
      wait_drain();
    end

    // Result held after RDY.
    repeat (5) @(negedge clock);
    check("hold_result", data_result, last_q);

    // Random operands, mixing small and full-range divisors.
    for (int i = 0; i < 10; i++) begin
      x = $urandom;
      y = ($urandom_range(0, 1) == 1) ? W'($urandom) : W'($urandom_range(1, 20));
      if ($urandom_range(0, 1) == 1) y = -y;
      start_op(x, y, 1'b1);
      wait_drain();
    end

    // Start while busy is ignored.
    start_op(W'(1000), W'(10), 1'b1);
    repeat (7) @(negedge clock);
    check("busy_mid", W'(busy), W'(1));
    data_operandA = W'(9);
    data_operandB = W'(3);
    ctrl_DIV = 1'b1;
    @(negedge clock);
    ctrl_DIV = 1'b0;
    wait_drain();
    @(negedge clock);
    check("busy_after", W'(busy), W'(0));

    // Exception flag set before the reset test so its clearing is visible.
    start_op(W'(5), W'(0), 1'b1);
    wait_drain();

    // Reset in the middle of an operation aborts it with no RDY pulse.
    start_op(W'(1000), W'(10), 1'b0);
    repeat (12) @(negedge clock);
    #1 reset = 1'b0;
    #1;
    check("midrst_result", data_result, W'(0));
    check("midrst_exception", W'(data_exception), W'(0));
    check("midrst_rdy", W'(data_resultRDY), W'(0));
    check("midrst_busy", W'(busy), W'(0));
`ifdef DIV_REMAINDER_EN
    check("midrst_remainder", data_remainder, W'(0));
`endif
    repeat (2) @(negedge clock);
    reset = 1'b1;
    repeat (40) @(negedge clock);
    start_op(W'(9), W'(3), 1'b1);
    wait_drain();

    // Back-to-back: start during the RDY cycle is ignored, next cycle accepted.
    start_op(W'(77), W'(5), 1'b1);
    for (int i = 0; i < 100 && !data_resultRDY; i++) @(negedge clock);
    check("b2b_rdy_seen", W'(data_resultRDY), W'(1));
    data_operandA = W'(50);
    data_operandB = W'(5);
    ctrl_DIV = 1'b1;
    @(negedge clock);
    begin
      exp_t e;
      data_operandA = W'(60);
      data_operandB = W'(7);
      e = model(W'(60), W'(7));
      e.edge_rdy = cyc + 1 + W + 1;
      sb.push_back(e);
    end
    @(negedge clock);
    ctrl_DIV = 1'b0;
    wait_drain();
    repeat (40) @(negedge clock);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
